xtea_dr_source: RTL and testbench

- Upstream feeder for the dual-rail asynchronous XTEA core.
- Accepts a 64-bit plaintext block and a 128-bit key on a synchronous valid/ready interface.
- Drives them onto the core's four-phase return-to-zero dual-rail channels (data_t/data_f, key_t/key_f) and sequences DATA -> NULL from the core's per-bit acknowledges.
- Completion detection and ack synchronisation live here, so the clocked host sees a plain streaming interface.

---
 rtl/xtea_dr_pkg.sv | 39 +++
 rtl/xtea_dr_source_if.sv | 27 ++
 rtl/dr_ack_sync.sv | 26 ++
 rtl/xtea_dr_source.sv | 129 ++++++++++++
 tb/tb_xtea_dr_source.sv | 398 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xtea_dr_pkg.sv
// Shared types for the dual-rail XTEA feeder: FSM states, channel widths and
// the {t, f} dual-rail encodings of the data and key channels.
package xtea_dr_pkg;

    localparam int DATA_W = 64;
    localparam int KEY_W  = 128;

    typedef enum logic [1:0] {
        WAIT_NULL     = 2'd0,
        IDLE          = 2'd1,
        WAIT_ACK      = 2'd2,
        WAIT_NULL_TOK = 2'd3
    } dr_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] t;
        logic [DATA_W-1:0] f;
    } dr_data_t;

    typedef struct packed {
        logic [KEY_W-1:0] t;
        logic [KEY_W-1:0] f;
    } dr_key_t;

    function automatic dr_data_t dr_enc_data(input logic [DATA_W-1:0] v);
        dr_data_t r;
        r.t = v;
        r.f = ~v;
        return r;
    endfunction

    function automatic dr_key_t dr_enc_key(input logic [KEY_W-1:0] v);
        dr_key_t r;
        r.t = v;
        r.f = ~v;
        return r;
    endfunction

endpackage

// File: rtl/xtea_dr_source_if.sv
// Host streaming channel plus the dual-rail data/key channels to the core.
// master = the feeder, slave = host and core side.
interface xtea_dr_source_if;
    import xtea_dr_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [KEY_W-1:0]  in_key;
    logic [DATA_W-1:0] in_enc_t;
    logic [DATA_W-1:0] in_enc_f;
    logic [DATA_W-1:0] in_enc_ack;
    logic [KEY_W-1:0]  key_t;
    logic [KEY_W-1:0]  key_f;
    logic [KEY_W-1:0]  key_ack;

    modport master (
        input  in_valid, in_data, in_key, in_enc_ack, key_ack,
        output in_ready, in_enc_t, in_enc_f, key_t, key_f
    );

    modport slave (
        output in_valid, in_data, in_key, in_enc_ack, key_ack,
        input  in_ready, in_enc_t, in_enc_f, key_t, key_f
    );

endinterface

// File: rtl/dr_ack_sync.sv
// Plain flop-chain synchroniser for one asynchronous completion level.
// Reset clears every stage so a stale completion can never leak through.
module dr_ack_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    assign sync_d = {sync_q[STAGES-2:0], d_i};
    assign q_o    = sync_q[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

endmodule

// File: rtl/xtea_dr_source.sv
// Clocked valid/ready to four-phase dual-rail feeder for the async XTEA core.
// Sequences DATA -> NULL from synchronised all-high / all-low ack reductions.
module xtea_dr_source
    import xtea_dr_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    xtea_dr_source_if.master bus,
    output logic             timeout_err,
    output logic [CNT_W-1:0] token_count
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

    dr_state_e        state_q;
    dr_data_t         data_q;
    dr_key_t          key_q;
    logic [CNT_W-1:0] tok_q;
    logic [TO_W-1:0]  phase_q, phase_d;
    logic             tmo_q, tmo_d;

    logic all_hi, all_lo;
    logic ack_hi_s, ack_lo_s;
    logic in_wait, state_change;

    // Acks rise and fall monotonically, so each reduction changes once per phase.
    assign all_hi = (&bus.in_enc_ack) & (&bus.key_ack);
    assign all_lo = ~((|bus.in_enc_ack) | (|bus.key_ack));

    dr_ack_sync #(.STAGES(SYNC_STAGES)) u_sync_hi (
        .clk   (clk),
        .rst_n (reset),
        .d_i   (all_hi),
        .q_o   (ack_hi_s)
    );

    dr_ack_sync #(.STAGES(SYNC_STAGES)) u_sync_lo (
        .clk   (clk),
        .rst_n (reset),
        .d_i   (all_lo),
        .q_o   (ack_lo_s)
    );

    assign bus.in_ready = (state_q == IDLE);
    assign bus.in_enc_t = data_q.t;
    assign bus.in_enc_f = data_q.f;
    assign bus.key_t    = key_q.t;
    assign bus.key_f    = key_q.f;
    assign timeout_err  = tmo_q;
    assign token_count  = tok_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= WAIT_NULL;
            data_q  <= '0;
            key_q   <= '0;
            tok_q   <= '0;
        end else begin
            case (state_q)
                WAIT_NULL: begin
                    if (ack_lo_s) state_q <= IDLE;
                end
                IDLE: begin
                    if (bus.in_valid) begin
                        data_q  <= dr_enc_data(bus.in_data);
                        key_q   <= dr_enc_key(bus.in_key);
                        state_q <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (ack_hi_s) begin
                        data_q  <= '0;
                        key_q   <= '0;
                        state_q <= WAIT_NULL_TOK;
                    end
                end
                WAIT_NULL_TOK: begin
                    if (ack_lo_s) begin
                        tok_q   <= tok_q + CNT_W'(1);
                        state_q <= IDLE;
                    end
                end
                default: state_q <= WAIT_NULL;
            endcase
        end
    end

    assign in_wait = (state_q == WAIT_ACK) || (state_q == WAIT_NULL_TOK);

    always_comb begin
        state_change = 1'b0;
        case (state_q)
            WAIT_NULL:     state_change = ack_lo_s;
            IDLE:          state_change = bus.in_valid;
            WAIT_ACK:      state_change = ack_hi_s;
            WAIT_NULL_TOK: state_change = ack_lo_s;
            default:       state_change = 1'b1;
        endcase
    end

    // Phase timer restarts on every transition and saturates at the limit;
    // the handshake keeps waiting after a timeout, only the flag is raised.
    always_comb begin
        phase_d = phase_q;
        if (state_change || !in_wait) begin
            phase_d = '0;
        end else if (phase_q != TO_LIMIT) begin
            phase_d = phase_q + TO_W'(1);
        end
        tmo_d = tmo_q | (TO_EN && in_wait && !state_change && (phase_d == TO_LIMIT));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: tb/tb_xtea_dr_source.sv
// Self-checking bench for xtea_dr_source: manual and zero-delay ack models,
// scoreboard of accepted blocks against rail DATA phases.
module tb_xtea_dr_source;
    import xtea_dr_pkg::*;

    localparam int S  = 2;
    localparam int TO = 16;
    localparam int NSTREAM = 1000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    xtea_dr_source_if ifc ();
    xtea_dr_source_if ifw ();

    logic        tmo, tmo_w;
    logic [15:0] tok;
    logic [3:0]  tok_w;

    logic              auto_ack = 1'b0;
    logic [DATA_W-1:0] man_enc_ack = '0;
    logic [KEY_W-1:0]  man_key_ack = '0;

    assign ifc.in_enc_ack = auto_ack ? (ifc.in_enc_t | ifc.in_enc_f) : man_enc_ack;
    assign ifc.key_ack    = auto_ack ? (ifc.key_t | ifc.key_f) : man_key_ack;
    assign ifw.in_enc_ack = ifw.in_enc_t | ifw.in_enc_f;
    assign ifw.key_ack    = ifw.key_t | ifw.key_f;

    xtea_dr_source #(.SYNC_STAGES(S), .TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (ifc),
        .timeout_err (tmo),
        .token_count (tok)
    );

    xtea_dr_source #(.SYNC_STAGES(S), .TIMEOUT_CYCLES(1024), .CNT_W(4)) dut_w (
        .clk         (clk),
        .reset       (reset),
        .bus         (ifw),
        .timeout_err (tmo_w),
        .token_count (tok_w)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [KEY_W-1:0]  k;
    } blk_t;
    blk_t sb_q[$];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rand_block(output logic [DATA_W-1:0] d, output logic [KEY_W-1:0] k);
        d = {$urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_ready_c();
        int n = 0;
        while (!ifc.in_ready && n < 200) begin
            tick(1);
            n++;
        end
    endtask

    task automatic test_reset();
        ifc.in_valid = 1'b0;
        ifc.in_data  = '0;
        ifc.in_key   = '0;
        ifw.in_valid = 1'b0;
        ifw.in_data  = '0;
        ifw.in_key   = '0;
        #2 reset = 1'b0;
        tick(2);
        checks++;
        if ({ifc.in_enc_t, ifc.in_enc_f, ifc.key_t, ifc.key_f} !== '0) begin
            failures++;
            $display("FAIL reset_rails: got nonzero t=%h f=%h want 0", ifc.in_enc_t, ifc.in_enc_f);
        end
        checks++;
        if ({ifc.in_ready, tmo, tok} !== '0) begin
            failures++;
            $display("FAIL reset_status: got ready=%b tmo=%b tok=%0d want 0/0/0", ifc.in_ready, tmo, tok);
        end
        reset = 1'b1;
        tick(S);
        checks++;
        if (ifc.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_wait_null: got in_ready=%b want 0", ifc.in_ready);
        end
        tick(1);
        checks++;
        if (ifc.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_idle: got in_ready=%b want 1", ifc.in_ready);
        end
        $display("reset: ready=%b tok=%0d", ifc.in_ready, tok);
    endtask

    task automatic test_basic();
        logic [KEY_W-1:0] kf_exp;
        kf_exp = '1;
        ifc.in_data  = 64'h0123456789ABCDEF;
        ifc.in_key   = '0;
        ifc.in_valid = 1'b1;
        tick(1);
        ifc.in_valid = 1'b0;
        checks++;
        if (ifc.in_enc_t !== 64'h0123456789ABCDEF || ifc.in_enc_f !== 64'hFEDCBA9876543210) begin
            failures++;
            $display("FAIL basic_data: got t=%h f=%h want 0123456789abcdef/fedcba9876543210", ifc.in_enc_t, ifc.in_enc_f);
        end
        checks++;
        if (ifc.key_t !== '0 || ifc.key_f !== kf_exp) begin
            failures++;
            $display("FAIL basic_key: got t=%h f=%h want 0/all-ones", ifc.key_t, ifc.key_f);
        end
        man_enc_ack = '1;
        man_key_ack = '1;
        tick(S);
        checks++;
        if (ifc.in_enc_t !== 64'h0123456789ABCDEF) begin
            failures++;
            $display("FAIL basic_hold: got t=%h want 0123456789abcdef", ifc.in_enc_t);
        end
        tick(1);
        checks++;
        if ({ifc.in_enc_t, ifc.in_enc_f, ifc.key_t, ifc.key_f} !== '0) begin
            failures++;
            $display("FAIL basic_null: got t=%h f=%h want 0", ifc.in_enc_t, ifc.in_enc_f);
        end
        man_enc_ack = '0;
        man_key_ack = '0;
        tick(S + 1);
        checks++;
        if (tok !== 16'd1 || ifc.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_token: got tok=%0d ready=%b want 1/1", tok, ifc.in_ready);
        end
        $display("basic: token done tok=%0d", tok);
    endtask

    task automatic test_partial();
        logic [DATA_W-1:0] d;
        logic [KEY_W-1:0]  k;
        rand_block(d, k);
        ifc.in_data  = d;
        ifc.in_key   = k;
        ifc.in_valid = 1'b1;
        tick(1);
        ifc.in_valid = 1'b0;
        man_enc_ack = 64'h7FFF_FFFF_FFFF_FFFF;
        man_key_ack = '1;
        tick(50);
        checks++;
        if (ifc.in_enc_t !== d || ifc.in_enc_f !== ~d || ifc.key_t !== k) begin
            failures++;
            $display("FAIL partial_hold: got t=%h f=%h want %h/%h", ifc.in_enc_t, ifc.in_enc_f, d, ~d);
        end
        man_enc_ack = '1;
        tick(S + 1);
        checks++;
        if ({ifc.in_enc_t, ifc.in_enc_f, ifc.key_t, ifc.key_f} !== '0) begin
            failures++;
            $display("FAIL partial_null: got t=%h f=%h want 0", ifc.in_enc_t, ifc.in_enc_f);
        end
        man_enc_ack = '0;
        man_key_ack = '0;
        tick(S + 1);
        checks++;
        if (tok !== 16'd2) begin
            failures++;
            $display("FAIL partial_token: got tok=%0d want 2", tok);
        end
        $display("partial: token done tok=%0d", tok);
    endtask

    task automatic test_reset_mid();
        logic [DATA_W-1:0] d;
        logic [KEY_W-1:0]  k;
        rand_block(d, k);
        wait_ready_c();
        ifc.in_data  = d;
        ifc.in_key   = k;
        ifc.in_valid = 1'b1;
        tick(1);
        ifc.in_valid = 1'b0;
        man_enc_ack = '1;
        man_key_ack = '1;
        tick(1);
        reset = 1'b0;
        #1;
        checks++;
        if ({ifc.in_enc_t, ifc.in_enc_f, ifc.key_t, ifc.key_f} !== '0 || ifc.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL midrst_null: got t=%h ready=%b want 0/0", ifc.in_enc_t, ifc.in_ready);
        end
        tick(3);
        reset = 1'b1;
        tick(5);
        checks++;
        if (ifc.in_ready !== 1'b0 || tok !== 16'd0) begin
            failures++;
            $display("FAIL midrst_block: got ready=%b tok=%0d want 0/0", ifc.in_ready, tok);
        end
        man_enc_ack = '0;
        man_key_ack = '0;
        tick(S);
        checks++;
        if (ifc.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL midrst_early: got in_ready=%b want 0", ifc.in_ready);
        end
        tick(1);
        checks++;
        if (ifc.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_idle: got in_ready=%b want 1", ifc.in_ready);
        end
        $display("reset_mid: ready=%b", ifc.in_ready);
    endtask

    task automatic test_timeout();
        logic [DATA_W-1:0] d;
        logic [KEY_W-1:0]  k;
        rand_block(d, k);
        ifc.in_data  = d;
        ifc.in_key   = k;
        ifc.in_valid = 1'b1;
        tick(1);
        ifc.in_valid = 1'b0;
        tick(TO - 1);
        checks++;
        if (tmo !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early: got timeout_err=%b want 0", tmo);
        end
        tick(1);
        checks++;
        if (tmo !== 1'b1) begin
            failures++;
            $display("FAIL timeout_set: got timeout_err=%b want 1", tmo);
        end
        tick(10);
        man_enc_ack = '1;
        man_key_ack = '1;
        tick(S + 1);
        checks++;
        if ({ifc.in_enc_t, ifc.in_enc_f} !== '0 || tmo !== 1'b1) begin
            failures++;
            $display("FAIL timeout_null: got t=%h tmo=%b want 0/1", ifc.in_enc_t, tmo);
        end
        man_enc_ack = '0;
        man_key_ack = '0;
        tick(S + 1);
        checks++;
        if (tok !== 16'd1 || tmo !== 1'b1 || ifc.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL timeout_token: got tok=%0d tmo=%b ready=%b want 1/1/1", tok, tmo, ifc.in_ready);
        end
        $display("timeout: tmo=%b tok=%0d", tmo, tok);
    endtask

    task automatic test_streaming();
        int sent = 0;
        int got = 0;
        int viol = 0;
        int cyc = 0;
        bit pend = 1'b0;
        bit prev_null = 1'b1;
        bit cur_null;
        blk_t e;
        logic [DATA_W-1:0] d;
        logic [KEY_W-1:0]  k;
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        auto_ack = 1'b1;
        wait_ready_c();
        rand_block(d, k);
        ifc.in_data  = d;
        ifc.in_key   = k;
        ifc.in_valid = 1'b1;
        while ((sent < NSTREAM || got < NSTREAM) && cyc < 30000) begin
            if ((ifc.in_enc_t & ifc.in_enc_f) != '0 || (ifc.key_t & ifc.key_f) != '0) viol++;
            cur_null = ({ifc.in_enc_t, ifc.in_enc_f, ifc.key_t, ifc.key_f} == '0);
            if (!cur_null && prev_null) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL stream_unexpected: got DATA t=%h with empty scoreboard", ifc.in_enc_t);
                end else begin
                    e = sb_q.pop_front();
                    if (ifc.in_enc_t !== e.d || ifc.in_enc_f !== ~e.d || ifc.key_t !== e.k || ifc.key_f !== ~e.k) begin
                        failures++;
                        $display("FAIL stream_data[%0d]: got t=%h key_t=%h want %h/%h", got, ifc.in_enc_t, ifc.key_t, e.d, e.k);
                    end
                    got++;
                end
            end
            prev_null = cur_null;
            if (pend) begin
                pend = 1'b0;
                if (sent < NSTREAM) begin
                    rand_block(d, k);
                    ifc.in_data = d;
                    ifc.in_key  = k;
                end else begin
                    ifc.in_valid = 1'b0;
                end
            end
            if (ifc.in_valid && ifc.in_ready) begin
                sb_q.push_back('{d: ifc.in_data, k: ifc.in_key});
                sent++;
                pend = 1'b1;
            end
            tick(1);
            cyc++;
        end
        ifc.in_valid = 1'b0;
        checks++;
        if (cyc >= 30000) begin
            failures++;
            $display("FAIL stream_timeout: got sent=%0d seen=%0d want %0d/%0d", sent, got, NSTREAM, NSTREAM);
        end
        for (int i = 0; i < 50 && tok != 16'(NSTREAM); i++) tick(1);
        checks++;
        if (tok !== 16'(NSTREAM) || sb_q.size() != 0) begin
            failures++;
            $display("FAIL stream_count: got tok=%0d left=%0d want %0d/0", tok, sb_q.size(), NSTREAM);
        end
        checks++;
        if (viol != 0) begin
            failures++;
            $display("FAIL stream_rails: got %0d cycles with t&f!=0 want 0", viol);
        end
        $display("streaming: tokens=%0d blocks_seen=%0d", tok, got);
        auto_ack = 1'b0;
    endtask

    task automatic test_wrap();
        int acc = 0;
        int cyc = 0;
        bit pend = 1'b0;
        logic [DATA_W-1:0] d;
        logic [KEY_W-1:0]  k;
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        rand_block(d, k);
        ifw.in_data  = d;
        ifw.in_key   = k;
        ifw.in_valid = 1'b1;
        while (acc < 17 && cyc < 2000) begin
            if (pend) begin
                pend = 1'b0;
                rand_block(d, k);
                ifw.in_data = d;
                ifw.in_key  = k;
            end
            if (ifw.in_valid && ifw.in_ready) begin
                acc++;
                pend = 1'b1;
            end
            tick(1);
            cyc++;
        end
        ifw.in_valid = 1'b0;
        tick(20);
        checks++;
        if (acc != 17 || tok_w !== 4'd1) begin
            failures++;
            $display("FAIL wrap_count: got accepted=%0d tok=%0d want 17/1", acc, tok_w);
        end
        $display("wrap: accepted=%0d tok=%0d", acc, tok_w);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_reset_mid();
        test_timeout();
        test_streaming();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
